riscv_mc_controller: RTL and testbench
======================================

# riscv_mc_controller

Multicycle control unit for the RV32I core: a Moore-style FSM plus combinational decode that sequences a shared-ALU, single-memory-port datapath (PC, IR, OldPC, ALUOut, Data registers) through fetch, decode, execute, memory and writeback steps. It supports the same instruction subset as the single-cycle core:

- lw, sw, jal
- add, sub, and, or, xor, slt, sll, srl, sra
- addi, andi, ori, xori, slti, slli, srli, srai
- beq, bne, blt, bge

It adds a memory-ready handshake, a sticky halt on illegal encodings, and a retired-instruction counter.

## Interface
- INSTRET_W, 32, width of retired-instruction counter
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- op  in  7  IR[6:0]; valid from DECODE onward
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- zero  in  1  ALU result == 0
- mem_ready  in  1  memory completes access this cycle
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR and OldPC enable
- result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1
- alu_src_b  out  2  00 rs2, 01 ImmExt, 10 constant 4
- imm_src  out  2  00 I, 01 S, 10 B, 11 J
- reg_write  out  1  register file write enable
- alu_control  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sra
- halted  out  1  sticky illegal-instruction flag
- instret  out  INSTRET_W  retired instruction count

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, HALT (4-bit encoding).
- Outputs not listed for a state are 0.
- FETCH
  - Drives adr_src=0, a=00, b=10, ALUOp=00, result_src=10.
  - Drives ir_write=pc_write=mem_ready.
  - Goes to DECODE when mem_ready=1; otherwise stays in FETCH.
- DECODE
  - Drives a=01, b=01, ALUOp=00, which computes the branch/jump target into ALUOut.
  - Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - any other op -> HALT
  - Also goes to HALT on a branch with funct3 in {010, 011, 110, 111}.
- MEMADR: drives a=10, b=01, ALUOp=00. Goes to MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: drives adr_src=1. Waits for mem_ready, then goes to MEMWB.
- MEMWRITE: drives adr_src=1, mem_write=1 (held every cycle in this state). On mem_ready goes to FETCH.
- MEMWB: drives result_src=01, reg_write=1. Goes to FETCH.
- EXECR: drives a=10, b=00, ALUOp=10. Goes to ALUWB.
- EXECI: drives a=10, b=01, ALUOp=10. Goes to ALUWB.
- ALUWB: drives result_src=00, reg_write=1. Goes to FETCH.
- BRANCH
  - Drives a=10, b=00, ALUOp=01, result_src=00, pc_write=taken. Goes to FETCH.
  - taken = zero for beq and bge; taken = ~zero for bne and blt.
- JAL: drives a=01, b=10, ALUOp=00, result_src=00, pc_write=1. Goes to ALUWB.
- HALT: all strobes 0; halted=1. Exits only on reset.
- ALU decode
  - ALUOp=00 -> add.
  - ALUOp=01 -> sub when funct3[2]=0; slt when funct3[2]=1.
  - ALUOp=10 decodes by funct3:
    - 000: sub if op[5] & funct7b5, else add
    - 001: sll
    - 010: slt
    - 100: xor
    - 101: sra if funct7b5, else srl
    - 110: or
    - 111: and
- imm_src is combinational from op: 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, all others -> 00.
- instret
  - Increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH.
  - Wraps modulo 2^INSTRET_W.

## Timing
- Zero-wait-state cycle counts: lw 5, sw 4, R/I-type 4, branch 3, jal 4.
- Each wait cycle (mem_ready=0) in FETCH, MEMREAD or MEMWRITE adds one cycle. The state and all outputs hold unchanged while waiting.
- State and instret are registered. All control outputs are combinational from state, op, funct3, funct7b5, zero and mem_ready.
- reset asserted
  - state = FETCH, instret = 0, halted = 0, effective immediately and asynchronously.
  - pc_write, ir_write, mem_write and reg_write are forced to 0 while reset is high.
- Reset asserted mid-MEMWRITE: mem_write drops in the same cycle, and the next access after release is an instruction fetch.
- mem_ready in any state other than FETCH, MEMREAD or MEMWRITE is ignored.

## Structure
- rv_mc_pkg holds:
  - state enum
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_B, OP_JAL)
  - ALUOp constants
  - alu_control code constants
  - mux-select constants for adr_src, result_src, alu_src_a, alu_src_b
- One sub-module, rv_mc_aludec: combinational ALUOp/funct3/funct7b5/op[5] -> alu_control.
- The FSM, imm_src decode, branch-taken logic and instret live in riscv_mc_controller.

## Test plan
- add x3,x1,x2 with mem_ready=1: states FETCH, DECODE, EXECR, ALUWB over 4 cycles; reg_write=1 only in cycle 4 with result_src=00; instret 0->1.
- lw with mem_ready=0 for 2 cycles in MEMREAD: 7 cycles total; adr_src=1 held for 3 cycles; reg_write with result_src=01 in the final cycle.
- beq/bne/blt/bge, each with zero=1 and then zero=0:
  - pc_write in BRANCH = 1,0 / 0,1 / 0,1 / 1,0.
  - alu_control = 0001, 0001, 0101, 0101.
- jal: pc_write=1 in JAL with a=01, b=10; then ALUWB with reg_write=1; 4 cycles; imm_src=11 in DECODE.
- Illegal op 0000000, then branch funct3=110: FSM enters HALT after DECODE, halted=1, all strobes 0 for 20 cycles, instret frozen; reset clears halted.
- Reset pulse during MEMWRITE with mem_ready=0: mem_write falls the same cycle; after release the FSM is in FETCH with adr_src=0 and instret=0.

Source files
------------

// File: rtl/rv_mc_pkg.sv
// Shared types and encodings for the RV32I multicycle controller.
package rv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/rv_mc_aludec.sv
// ALU operation decode from ALUOp class and instruction fields.
module rv_mc_aludec
  import rv_mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [3:0] alu_control
);

  // funct7b5 only selects sub for R-type; for I-type it is an immediate bit
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_BR: alu_control = funct3[2] ? ALU_SLT : ALU_SUB;
      ALUOP_FN: begin
        case (funct3)
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multicycle RV32I control unit: sequencing FSM, imm_src decode,
// branch resolution and retired-instruction counter.
//
// state    | meaning
// FETCH    | read instruction at PC, PC += 4 (waits on mem_ready)
// DECODE   | ALUOut = OldPC + imm (branch/jump target), dispatch on op
// MEMADR   | ALUOut = rs1 + imm (load/store address)
// MEMREAD  | read data at ALUOut (waits on mem_ready)
// MEMWB    | rd = Data
// MEMWRITE | write rs2 at ALUOut (waits on mem_ready)
// EXECR    | ALUOut = rs1 op rs2
// EXECI    | ALUOut = rs1 op imm
// ALUWB    | rd = ALUOut
// BRANCH   | compare rs1/rs2, PC = ALUOut if taken
// JAL      | PC = ALUOut, ALUOut = OldPC + 4 for link
// HALT     | illegal encoding seen; frozen until reset
module riscv_mc_controller
  import rv_mc_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           imm_src,
  output logic                 reg_write,
  output logic [3:0]           alu_control,
  output logic                 halted,
  output logic [INSTRET_W-1:0] instret
);

  state_t     state, state_next;
  logic [1:0] alu_op;
  logic       retire;
  logic       taken;
  logic       pc_write_i, mem_write_i, ir_write_i, reg_write_i;

  // beq/bge take on zero, bne/blt on ~zero (blt/bge compare via slt)
  assign taken  = zero ^ (funct3[0] ^ funct3[2]);
  assign retire = (state_next == S_FETCH) &&
                  (state == S_MEMWB || state == S_MEMWRITE ||
                   state == S_ALUWB || state == S_BRANCH);
  assign halted = (state == S_HALT);

  // next-state selection
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:    if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_B:         state_next = funct3[1] ? S_HALT : S_BRANCH;
          OP_JAL:       state_next = S_JAL;
          default:      state_next = S_HALT;
        endcase
      end
      S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      S_HALT:     state_next = S_HALT;
      default:    state_next = S_FETCH;
    endcase
  end

  // state register and retired-instruction counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_FETCH;
      instret <= '0;
    end else begin
      state <= state_next;
      if (retire) instret <= instret + INSTRET_W'(1);
    end
  end

  // per-state datapath controls; anything not driven stays 0
  always_comb begin
    pc_write_i  = 1'b0;
    mem_write_i = 1'b0;
    ir_write_i  = 1'b0;
    reg_write_i = 1'b0;
    adr_src     = ADR_PC;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    alu_op      = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write_i = mem_ready;
        pc_write_i = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD:  adr_src = ADR_ALUOUT;
      S_MEMWRITE: begin
        adr_src     = ADR_ALUOUT;
        mem_write_i = 1'b1;
      end
      S_MEMWB: begin
        result_src  = RES_DATA;
        reg_write_i = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FN;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FN;
      end
      S_ALUWB: reg_write_i = 1'b1;
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALUOP_BR;
        pc_write_i = taken;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_write_i = 1'b1;
      end
      default: ;
    endcase
  end

  // immediate format follows the opcode regardless of state
  always_comb begin
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_B:    imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

  // strobes are suppressed for the whole reset pulse, not just after the edge
  assign pc_write  = pc_write_i  & ~reset;
  assign mem_write = mem_write_i & ~reset;
  assign ir_write  = ir_write_i  & ~reset;
  assign reg_write = reg_write_i & ~reset;

  rv_mc_aludec u_aludec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Cycle-by-cycle scoreboard bench for the multicycle controller.
module tb_riscv_mc_controller;
  import rv_mc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5, zero, mem_ready;
  logic        pc_write, adr_src, mem_write, ir_write, reg_write, halted;
  logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
  logic [3:0]  alu_control;
  logic [31:0] instret;

  riscv_mc_controller #(.INSTRET_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .reg_write(reg_write), .alu_control(alu_control), .halted(halted),
    .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] res;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] imm;
    logic       regw;
    logic [3:0] alu;
    logic       hlt;
  } ctl_t;

  ctl_t        act;
  ctl_t        exp_q[$];
  logic [31:0] ir_q[$];
  logic [31:0] ir_exp = 32'd0;
  int          n_checks = 0;
  int          n_pass = 0;

  assign act = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                alu_src_b, imm_src, reg_write, alu_control, halted};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  function automatic ctl_t mk(input logic pcw, input logic adr, input logic memw,
                              input logic irw, input logic [1:0] res, input logic [1:0] a,
                              input logic [1:0] b, input logic regw, input logic [3:0] alu,
                              input logic hlt);
    ctl_t e;
    e = {pcw, adr, memw, irw, res, a, b, imm_of(op), regw, alu, hlt};
    return e;
  endfunction

  // push expectation at drive time, pop and compare mid-cycle
  task automatic cyc(input string tag, input ctl_t e);
    ctl_t        ex;
    logic [31:0] ie;
    exp_q.push_back(e);
    ir_q.push_back(ir_exp);
    @(negedge clk);
    ex = exp_q.pop_front();
    ie = ir_q.pop_front();
    check({tag, " ctl"}, 32'(act), 32'(ex));
    check({tag, " instret"}, instret, ie);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
  endtask

  task automatic fetch(input int waits);
    mem_ready = 1'b0;
    for (int i = 0; i < waits; i++)
      cyc("fetch_wait", mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, 4'h0, 0));
    mem_ready = 1'b1;
    cyc("fetch", mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, 4'h0, 0));
  endtask

  task automatic decode();
    mem_ready = 1'b0;
    cyc("decode", mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 4'h0, 0));
  endtask

  task automatic run_alu(input string tag, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic [3:0] alu);
    set_instr(o, f3, f7, 1'b0);
    fetch(0);
    decode();
    mem_ready = 1'b1;
    cyc(tag, mk(0, 0, 0, 0, 2'b00, 2'b10, (o == 7'b0110011) ? 2'b00 : 2'b01, 0, alu, 0));
    cyc("aluwb", mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 4'h0, 0));
    ir_exp++;
  endtask

  task automatic run_lw(input int waits);
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
    fetch(0);
    decode();
    cyc("lw_memadr", mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 4'h0, 0));
    for (int i = 0; i < waits; i++)
      cyc("lw_memread_wait", mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'h0, 0));
    mem_ready = 1'b1;
    cyc("lw_memread", mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'h0, 0));
    mem_ready = 1'b0;
    cyc("lw_memwb", mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 4'h0, 0));
    ir_exp++;
  endtask

  task automatic run_sw(input int fwaits, input int mwaits);
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    fetch(fwaits);
    decode();
    cyc("sw_memadr", mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 4'h0, 0));
    for (int i = 0; i < mwaits; i++)
      cyc("sw_memwrite_wait", mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 4'h0, 0));
    mem_ready = 1'b1;
    cyc("sw_memwrite", mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 4'h0, 0));
    ir_exp++;
  endtask

  task automatic run_br(input string tag, input logic [2:0] f3, input logic z,
                        input logic tk, input logic [3:0] alu);
    set_instr(7'b1100011, f3, 1'b0, z);
    fetch(0);
    decode();
    cyc(tag, mk(tk, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, alu, 0));
    ir_exp++;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    ir_exp = 32'd0;
    cyc(tag, mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, 4'h0, 0));
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    set_instr(7'b0110011, 3'b000, 1'b0, 1'b0);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset("reset");

    run_alu("add",  7'b0110011, 3'b000, 1'b0, 4'b0000);
    run_alu("sub",  7'b0110011, 3'b000, 1'b1, 4'b0001);
    run_alu("sll",  7'b0110011, 3'b001, 1'b0, 4'b0110);
    run_alu("slt",  7'b0110011, 3'b010, 1'b0, 4'b0101);
    run_alu("xor",  7'b0110011, 3'b100, 1'b0, 4'b0100);
    run_alu("srl",  7'b0110011, 3'b101, 1'b0, 4'b0111);
    run_alu("sra",  7'b0110011, 3'b101, 1'b1, 4'b1000);
    run_alu("or",   7'b0110011, 3'b110, 1'b0, 4'b0011);
    run_alu("and",  7'b0110011, 3'b111, 1'b0, 4'b0010);
    run_alu("addi_b30", 7'b0010011, 3'b000, 1'b1, 4'b0000);
    run_alu("xori", 7'b0010011, 3'b100, 1'b0, 4'b0100);
    run_alu("slli", 7'b0010011, 3'b001, 1'b0, 4'b0110);
    run_alu("srai", 7'b0010011, 3'b101, 1'b1, 4'b1000);

    run_lw(2);
    run_lw(0);
    run_sw(1, 2);

    run_br("beq_z1", 3'b000, 1'b1, 1'b1, 4'b0001);
    run_br("beq_z0", 3'b000, 1'b0, 1'b0, 4'b0001);
    run_br("bne_z1", 3'b001, 1'b1, 1'b0, 4'b0001);
    run_br("bne_z0", 3'b001, 1'b0, 1'b1, 4'b0001);
    run_br("blt_z1", 3'b100, 1'b1, 1'b0, 4'b0101);
    run_br("blt_z0", 3'b100, 1'b0, 1'b1, 4'b0101);
    run_br("bge_z1", 3'b101, 1'b1, 1'b1, 4'b0101);
    run_br("bge_z0", 3'b101, 1'b0, 1'b0, 4'b0101);

    set_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
    fetch(0);
    decode();
    cyc("jal", mk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 4'h0, 0));
    cyc("jal_aluwb", mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 4'h0, 0));
    ir_exp++;

    set_instr(7'b0000000, 3'b000, 1'b0, 1'b0);
    fetch(0);
    decode();
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      cyc("halt_illegal", mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'h0, 1));
    end
    do_reset("halt_reset");

    set_instr(7'b1100011, 3'b110, 1'b0, 1'b1);
    fetch(0);
    decode();
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1;
      cyc("halt_badbr", mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'h0, 1));
    end
    do_reset("badbr_reset");

    run_alu("add_pre_mw", 7'b0110011, 3'b000, 1'b0, 4'b0000);
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    fetch(0);
    decode();
    cyc("mw_memadr", mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 4'h0, 0));
    mem_ready = 1'b0;
    cyc("mw_hold", mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 4'h0, 0));
    #1;
    check("mw_before_reset", 32'(mem_write), 32'd1);
    reset = 1'b1;
    #1;
    check("mw_drop_on_reset", 32'(mem_write), 32'd0);
    check("mw_instret_cleared", instret, 32'd0);
    ir_exp = 32'd0;
    cyc("mw_in_reset", mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, 4'h0, 0));
    reset = 1'b0;
    set_instr(7'b0110011, 3'b000, 1'b0, 1'b0);
    fetch(0);
    decode();
    cyc("post_reset_exec", mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 4'h0, 0));
    cyc("post_reset_aluwb", mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 4'h0, 0));
    ir_exp++;
    fetch(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
